// File: rtl/softmax_seq_ctrl_if.sv
// softmax_seq_ctrl_if
//   Handshake bundle between the softmax sequencer and its stream neighbours.
//   Input side : in_valid (producer -> sequencer), in_ready (sequencer -> producer)
//   Output side: out_valid (sequencer -> consumer), out_ready (consumer -> sequencer)
//   Modports:
//     slave  - the sequencer: accepts the input stream, presents results
//     master - the surrounding stream logic / testbench
interface softmax_seq_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport slave (
    input  in_valid,
    output in_ready,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_valid,
    input  in_ready,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl
//   Sequencer for the softmax engine. Loads one vector of runtime length into
//   the IFM buffer, optionally sweeps it once for the maximum, sweeps it once
//   per LUT segment for exp/accumulate, captures the sum, then drains the
//   normalised results through a valid/ready port.
//
//   Optional feature macro: SMX_MAXPASS_EN
//     defined   - MAX and WAIT_M states present, pass_max can assert
//     undefined - WAIT_L goes straight to EXP, pass_max tied to 0
//
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     start, len      request to process a vector of len samples (IDLE only)
//     stream          slave side of softmax_seq_ctrl_if (in/out handshakes)
//     buf_wr_en/addr  buffer write strobe (= in_valid & in_ready) and address
//     buf_rd_en/addr  buffer read strobe and address (also result address)
//     rd_data_vld     buf_rd_en delayed by the one-cycle RAM latency
//     pass_max        current read pass is the max search
//     seg_idx         LUT segment of the current exp pass
//     acc_clr         one-cycle accumulator / max register clear
//     cap_en          one-cycle capture of the final sum into the divider
//     busy            high in every state except IDLE
//     done            one-cycle pulse after the last result is accepted
//     err_len         one-cycle pulse on start with len==0 or len>MAX_LEN
module softmax_seq_ctrl #(
  parameter  int DATA_WIDTH = 16,
  parameter  int MAX_LEN    = 1024,
  parameter  int LUT_SEGS   = 100,
  localparam int AW         = $clog2(MAX_LEN),
  localparam int SW         = (LUT_SEGS > 1) ? $clog2(LUT_SEGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW:0]       len,
  softmax_seq_ctrl_if.slave stream,
  output logic              buf_wr_en,
  output logic [AW-1:0]     buf_wr_addr,
  output logic              buf_rd_en,
  output logic [AW-1:0]     buf_rd_addr,
  output logic              rd_data_vld,
  output logic              pass_max,
  output logic [SW-1:0]     seg_idx,
  output logic              acc_clr,
  output logic              cap_en,
  output logic              busy,
  output logic              done,
  output logic              err_len
);

  localparam int LEN_W = AW + 1;

  typedef enum logic [3:0] {
    IDLE, LOAD, WAIT_L, MAX, WAIT_M, EXP, GAP, CAP, DRAIN, DONE
  } state_t;

  state_t           state_reg;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] wcnt_reg;
  logic [LEN_W-1:0] rcnt_reg;
  logic [SW-1:0]    seg_reg;

  logic in_ready_reg;
  logic out_valid_reg;
  logic buf_rd_en_reg;
  logic rd_data_vld_reg;
  logic acc_clr_reg;
  logic cap_en_reg;
  logic busy_reg;
  logic done_reg;
  logic err_len_reg;
`ifdef SMX_MAXPASS_EN
  logic pass_max_reg;
`endif

  logic [LEN_W-1:0] len_last;
  logic             len_ok;
  logic             wr_last;
  logic             rd_last;
  logic             seg_last;

  assign len_last = len_r - LEN_W'(1);
  assign len_ok   = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign wr_last  = (wcnt_reg == len_last);
  assign rd_last  = (rcnt_reg == len_last);
  assign seg_last = (seg_reg == SW'(LUT_SEGS - 1));

  // Every output except buf_wr_en is a register updated alongside the state,
  // so each one is already valid for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      len_r           <= '0;
      wcnt_reg        <= '0;
      rcnt_reg        <= '0;
      seg_reg         <= '0;
      in_ready_reg    <= 1'b0;
      out_valid_reg   <= 1'b0;
      buf_rd_en_reg   <= 1'b0;
      rd_data_vld_reg <= 1'b0;
      acc_clr_reg     <= 1'b0;
      cap_en_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_len_reg     <= 1'b0;
`ifdef SMX_MAXPASS_EN
      pass_max_reg    <= 1'b0;
`endif
    end else begin
      // single-cycle pulses default low
      acc_clr_reg     <= 1'b0;
      cap_en_reg      <= 1'b0;
      done_reg        <= 1'b0;
      err_len_reg     <= 1'b0;
      rd_data_vld_reg <= buf_rd_en_reg;

      case (state_reg)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state_reg    <= LOAD;
              len_r        <= len;
              wcnt_reg     <= '0;
              acc_clr_reg  <= 1'b1;
              busy_reg     <= 1'b1;
              in_ready_reg <= 1'b1;
            end else begin
              err_len_reg  <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (stream.in_valid) begin
            if (wr_last) begin
              // last write: clear here so wcnt never exceeds len_r-1
              state_reg    <= WAIT_L;
              wcnt_reg     <= '0;
              in_ready_reg <= 1'b0;
            end else begin
              wcnt_reg     <= wcnt_reg + LEN_W'(1);
            end
          end
        end

        WAIT_L: begin
          wcnt_reg      <= '0;
          rcnt_reg      <= '0;
          seg_reg       <= '0;
          buf_rd_en_reg <= 1'b1;
`ifdef SMX_MAXPASS_EN
          state_reg     <= MAX;
          pass_max_reg  <= 1'b1;
`else
          state_reg     <= EXP;
`endif
        end

`ifdef SMX_MAXPASS_EN
        MAX: begin
          if (rd_last) begin
            state_reg     <= WAIT_M;
            rcnt_reg      <= '0;
            pass_max_reg  <= 1'b0;
            buf_rd_en_reg <= 1'b0;
            // clear lands during WAIT_M, after the last max sample is in
            acc_clr_reg   <= 1'b1;
          end else begin
            rcnt_reg      <= rcnt_reg + LEN_W'(1);
          end
        end

        WAIT_M: begin
          state_reg     <= EXP;
          seg_reg       <= '0;
          rcnt_reg      <= '0;
          buf_rd_en_reg <= 1'b1;
        end
`endif

        EXP: begin
          if (rd_last) begin
            state_reg     <= GAP;
            rcnt_reg      <= '0;
            buf_rd_en_reg <= 1'b0;
          end else begin
            rcnt_reg      <= rcnt_reg + LEN_W'(1);
          end
        end

        GAP: begin
          if (seg_last) begin
            state_reg     <= CAP;
            cap_en_reg    <= 1'b1;
          end else begin
            state_reg     <= EXP;
            seg_reg       <= seg_reg + SW'(1);
            buf_rd_en_reg <= 1'b1;
          end
        end

        CAP: begin
          state_reg     <= DRAIN;
          rcnt_reg      <= '0;
          out_valid_reg <= 1'b1;
        end

        DRAIN: begin
          if (stream.out_ready) begin
            if (rd_last) begin
              state_reg     <= DONE;
              rcnt_reg      <= '0;
              out_valid_reg <= 1'b0;
              done_reg      <= 1'b1;
            end else begin
              rcnt_reg      <= rcnt_reg + LEN_W'(1);
            end
          end
        end

        DONE: begin
          // start is not looked at here; it is only honoured in IDLE
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          wcnt_reg  <= '0;
          rcnt_reg  <= '0;
          seg_reg   <= '0;
        end

        default: begin
          state_reg     <= IDLE;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          buf_rd_en_reg <= 1'b0;
          wcnt_reg      <= '0;
          rcnt_reg      <= '0;
          seg_reg       <= '0;
        end
      endcase
    end
  end

  assign stream.in_ready  = in_ready_reg;
  assign stream.out_valid = out_valid_reg;

  assign buf_wr_en   = stream.in_valid & in_ready_reg;
  assign buf_wr_addr = wcnt_reg[AW-1:0];
  assign buf_rd_en   = buf_rd_en_reg;
  assign buf_rd_addr = rcnt_reg[AW-1:0];
  assign rd_data_vld = rd_data_vld_reg;
  assign seg_idx     = seg_reg;
  assign acc_clr     = acc_clr_reg;
  assign cap_en      = cap_en_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err_len     = err_len_reg;
`ifdef SMX_MAXPASS_EN
  assign pass_max    = pass_max_reg;
`else
  assign pass_max    = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb_softmax_seq_ctrl
//   Self-checking bench for softmax_seq_ctrl (MAX_LEN=16, LUT_SEGS=3).
//   Table of whole-vector runs plus hand-written reset / idle sequences.
//   Works with SMX_MAXPASS_EN defined or undefined.
module tb_softmax_seq_ctrl;
  localparam int MAX_LEN  = 16;
  localparam int LUT_SEGS = 3;
  localparam int AW       = $clog2(MAX_LEN);
  localparam int SW       = $clog2(LUT_SEGS);
  localparam int BUDGET   = 400;
`ifdef SMX_MAXPASS_EN
  localparam int MAXP = 1;
`else
  localparam int MAXP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   len;
  logic          buf_wr_en, buf_rd_en, rd_data_vld, pass_max;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
  logic [SW-1:0] seg_idx;
  logic          acc_clr, cap_en, busy, done, err_len;

  softmax_seq_ctrl_if sif ();

  softmax_seq_ctrl #(
    .DATA_WIDTH (16),
    .MAX_LEN    (MAX_LEN),
    .LUT_SEGS   (LUT_SEGS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
    .stream      (sif.slave),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .rd_data_vld (rd_data_vld),
    .pass_max    (pass_max),
    .seg_idx     (seg_idx),
    .acc_clr     (acc_clr),
    .cap_en      (cap_en),
    .busy        (busy),
    .done        (done),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},        busy, 0);
    chk({tag, ".in_ready"},    sif.in_ready, 0);
    chk({tag, ".out_valid"},   sif.out_valid, 0);
    chk({tag, ".done"},        done, 0);
    chk({tag, ".err_len"},     err_len, 0);
    chk({tag, ".acc_clr"},     acc_clr, 0);
    chk({tag, ".cap_en"},      cap_en, 0);
    chk({tag, ".rd_data_vld"}, rd_data_vld, 0);
    chk({tag, ".buf_rd_en"},   buf_rd_en, 0);
    chk({tag, ".buf_wr_en"},   buf_wr_en, 0);
    chk({tag, ".pass_max"},    pass_max, 0);
    chk({tag, ".buf_wr_addr"}, buf_wr_addr, 0);
    chk({tag, ".buf_rd_addr"}, buf_rd_addr, 0);
    chk({tag, ".seg_idx"},     seg_idx, 0);
  endtask

  // one vector run: inputs plus hand-computed expectations
  typedef struct {
    string name;
    int    len;      // requested length
    bit    toggle;   // in_valid alternates 0/1 instead of held high
    bit    stall;    // out_ready low for 3 cycles while rcnt==2
    bit    restart;  // extra start pulses during LOAD and on DONE
    bit    exp_err;  // expect err_len and no activity
    int    exp_lat;  // cycles from start to first out_valid, -1 = not checked
  } vec_t;

  task automatic run_vec(input vec_t v);
    int nwr = 0, nmax = 0, nexp = 0, ncap = 0, nout = 0;
    int ndone = 0, nerr = 0, nacc = 0;
    int first_ov = -1, done_cyc = -1, last_hs = -1, stalls = 0;
    int n = v.len;
    int exp_busy;
    bit prev_rd = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      // outputs are stable here, so they can steer this cycle's inputs
      start = (cyc == 0) || (v.restart && (cyc == 3 || done));
      len   = (cyc == 0) ? (AW+1)'(v.len) : (AW+1)'(2);
      sif.in_valid  = v.toggle ? ((cyc % 2) == 1) : 1'b1;
      sif.out_ready = 1'b1;
      if (v.stall && sif.out_valid && nout == 2 && stalls < 3) begin
        sif.out_ready = 1'b0;
        stalls++;
      end
      #1;
      chk({v.name, ".rd_data_vld"}, rd_data_vld, prev_rd);
      prev_rd = buf_rd_en;
      if (buf_wr_en) begin
        chk({v.name, ".wr_addr"}, buf_wr_addr, nwr);
        nwr++;
      end
      if (buf_rd_en && pass_max) begin
        chk({v.name, ".max_addr"}, buf_rd_addr, nmax);
        nmax++;
      end
      if (buf_rd_en && !pass_max && n > 0) begin
        chk({v.name, ".exp_addr"}, buf_rd_addr, nexp % n);
        chk({v.name, ".seg_idx"}, seg_idx, nexp / n);
        nexp++;
      end
      if (MAXP == 0) chk({v.name, ".pass_max_tied"}, pass_max, 0);
      if (acc_clr) nacc++;
      if (cyc == 1 && !v.exp_err) chk({v.name, ".acc_clr_start"}, acc_clr, 1);
      if (cyc == 1 && v.exp_err)  chk({v.name, ".err_pulse"}, err_len, 1);
      if (cap_en) begin
        ncap++;
        chk({v.name, ".reads_before_cap"}, nexp, LUT_SEGS * n);
      end
      if (sif.out_valid && first_ov < 0) first_ov = cyc;
      if (sif.out_valid && !sif.out_ready) chk({v.name, ".stall_addr"}, buf_rd_addr, 2);
      if (sif.out_valid && sif.out_ready) begin
        chk({v.name, ".out_addr"}, buf_rd_addr, nout);
        nout++;
        last_hs = cyc;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk({v.name, ".done_after_last"}, cyc, last_hs + 1);
      end
      if (err_len) nerr++;
      exp_busy = (v.exp_err || cyc == 0 || (done_cyc >= 0 && cyc > done_cyc)) ? 0 : 1;
      chk({v.name, ".busy"}, busy, exp_busy);
      if (v.exp_err && cyc >= 4) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;
    if (v.exp_err) begin
      chk({v.name, ".err_count"}, nerr, 1);
      chk({v.name, ".writes"}, nwr, 0);
    end else begin
      chk({v.name, ".writes"},  nwr, n);
      chk({v.name, ".max_reads"}, nmax, MAXP * n);
      chk({v.name, ".exp_reads"}, nexp, LUT_SEGS * n);
      chk({v.name, ".cap_count"}, ncap, 1);
      chk({v.name, ".out_count"}, nout, n);
      chk({v.name, ".done_count"}, ndone, 1);
      chk({v.name, ".acc_clr_count"}, nacc, 1 + MAXP);
      chk({v.name, ".err_count"}, nerr, 0);
      if (v.stall) chk({v.name, ".stall_cycles"}, stalls, 3);
      if (v.exp_lat >= 0) chk({v.name, ".latency"}, first_ov, v.exp_lat);
    end
    $display("run %s len=%0d: writes=%0d max=%0d exp=%0d outs=%0d first_ov=%0d done_cyc=%0d",
             v.name, v.len, nwr, nmax, nexp, nout, first_ov, done_cyc);
  endtask

  vec_t vecs[7];

  initial begin
    // latency = 1 + N + 1 + [N+1] + 3*(N+1) + 1
    vecs[0] = '{"len4",       4,  1'b0, 1'b0, 1'b0, 1'b0, (MAXP != 0) ? 27 : 22};
    vecs[1] = '{"len1",       1,  1'b0, 1'b0, 1'b0, 1'b0, (MAXP != 0) ? 12 : 10};
    vecs[2] = '{"lenmax_tog", 16, 1'b1, 1'b0, 1'b0, 1'b0, -1};
    vecs[3] = '{"len0",       0,  1'b0, 1'b0, 1'b0, 1'b1, -1};
    vecs[4] = '{"len17",      17, 1'b0, 1'b0, 1'b0, 1'b1, -1};
    vecs[5] = '{"stall",      4,  1'b0, 1'b1, 1'b0, 1'b0, (MAXP != 0) ? 27 : 22};
    vecs[6] = '{"restart",    4,  1'b0, 1'b0, 1'b1, 1'b0, (MAXP != 0) ? 27 : 22};

    rst_n = 1'b0;
    start = 1'b0;
    len   = '0;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // abort mid-LOAD: 5 of 8 samples written, then asynchronous reset
    @(negedge clk);
    start = 1'b1;
    len   = (AW+1)'(8);
    sif.in_valid  = 1'b1;
    sif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("midload.wr_addr", buf_wr_addr, 5);
    chk("midload.busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midload_rst");
    sif.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_all_zero("midload_hold");
    rst_n = 1'b1;
    $display("run midload_reset: aborted after 5 writes");
    run_vec('{"after_rst", 8, 1'b0, 1'b0, 1'b0, 1'b0, (MAXP != 0) ? 47 : 38});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_seq_ctrl.md
# softmax_seq_ctrl

Parametrised sequencer for the softmax engine. It loads one vector of runtime length into the IFM buffer through a valid/ready handshake. It then sweeps the buffer once for the max, and once per LUT segment for exp/accumulate. Finally it drains normalised results through a valid/ready output port. It drives buffer addresses/enables, LUT segment select and accumulator controls, and sits between the input stream interface and the softmax datapath.

## Interface
- DATA_WIDTH, 16, IFM sample width (datapath only; the controller passes no data)
- MAX_LEN, 1024, buffer depth in samples; AW = $clog2(MAX_LEN)
- LUT_SEGS, 100, number of LUT segment passes; SW = $clog2(LUT_SEGS)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to process a vector; sampled in IDLE only
- len  in  AW+1  vector length, sampled with start
- in_valid / in_ready  in/out  1  input-sample handshake
- buf_wr_en  out  1  buffer write strobe (= in_valid & in_ready)
- buf_wr_addr  out  AW  write address
- buf_rd_en  out  1  buffer read strobe
- buf_rd_addr  out  AW  read address
- rd_data_vld  out  1  buf_rd_en delayed one cycle (RAM latency 1)
- pass_max  out  1  current read pass is the max search
- seg_idx  out  SW  LUT segment of the current exp pass
- acc_clr  out  1  clear the accumulator/max register, one cycle
- cap_en  out  1  one-cycle capture of the final sum into the divider
- out_valid / out_ready  out/in  1  result handshake; addr = buf_rd_addr
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result is accepted
- err_len  out  1  one-cycle pulse when start is given with len==0 or len>MAX_LEN

## Operation
- States: IDLE, LOAD, WAIT_L, MAX, WAIT_M, EXP, GAP, CAP, DRAIN, DONE.
- IDLE: start with a legal len latches len_r and goes to LOAD with acc_clr=1. An illegal len pulses err_len and stays in IDLE.
- LOAD: in_ready=1. Each handshake writes at wcnt and then increments wcnt. When the handshake writes address len_r-1, go to WAIT_L.
- WAIT_L: one cycle, wcnt cleared. Next state is MAX (SMX_MAXPASS_EN defined) or EXP.
- MAX: pass_max=1, buf_rd_en=1 every cycle, rcnt counts 0..len_r-1, then WAIT_M.
- WAIT_M: one cycle; lets the last rd_data_vld land. acc_clr=1; then EXP with seg=0.
- EXP: buf_rd_en=1, seg_idx=seg, rcnt counts 0..len_r-1, then GAP.
- GAP: one cycle, buf_rd_en=0. If seg==LUT_SEGS-1, go to CAP; else seg+1 and return to EXP.
- CAP: cap_en=1 for one cycle; rcnt cleared; then DRAIN.
- DRAIN: out_valid=1. Address = rcnt, which advances only on out_valid&out_ready. On the handshake with rcnt==len_r-1, go to DONE.
- DONE: done=1 for one cycle; then IDLE.
- All outputs are decoded from the registered state and counters (Moore). No output depends combinationally on in_valid or out_ready, except buf_wr_en.
- Counters: wcnt/rcnt are AW+1 bits and seg is SW bits. All counters clear to 0 on entry to IDLE and never wrap past len_r-1 / LUT_SEGS-1.

## Timing
- Reset: state=IDLE, all counters 0, len_r=0. Every output is 0 (busy, in_ready, out_valid, done, err_len, acc_clr, cap_en, rd_data_vld included).
- Reset asserted mid-operation aborts immediately to IDLE. No done is generated; the buffer contents are don't-care.
- LOAD accepts one sample per cycle at full rate. in_valid low stalls with no write.
- Read pass of N samples = N cycles. rd_data_vld trails buf_rd_en by exactly 1 cycle.
- Total latency from start to first out_valid, with in_valid held high: 1 + N + 1 + [N + 1] + LUT_SEGS·(N+1) + 1 cycles. The bracketed term is present only with SMX_MAXPASS_EN.
- start while busy is ignored. start and a pending DONE in the same cycle: start is ignored.
- out_ready low holds buf_rd_addr and out_valid stable.

## Configuration
- SMX_MAXPASS_EN defined: the MAX/WAIT_M states are present. pass_max can assert, and acc_clr pulses on WAIT_M.
- Undefined: MAX/WAIT_M are removed, WAIT_L goes straight to EXP, and pass_max is tied 0. This is for inputs pre-normalised upstream.

## Test plan
- Reset mid-LOAD after 5 of len=8 samples → all outputs 0, state IDLE. A following start with len=8 works normally.
- len=4, LUT_SEGS=3, in_valid constant, out_ready constant, macro defined:
  - 4 writes at addresses 0..3;
  - MAX pass reads 0..3;
  - seg_idx 0,1,2, each a 4-cycle read with one GAP cycle between;
  - one cap_en, 4 out handshakes, done 1 cycle after the last.
- Same run without SMX_MAXPASS_EN → pass_max never high; first out_valid 5 cycles earlier.
- start with len=0 and with len=MAX_LEN+1 → err_len one-cycle pulse, busy stays 0.
- len=MAX_LEN with in_valid toggling 1/0 → exactly MAX_LEN writes, addresses 0..MAX_LEN-1, no wrap.
- DRAIN with out_ready low for 3 cycles at rcnt=2 → buf_rd_addr holds 2 and out_valid stays 1; completes after out_ready returns.
